// File: rtl/day2_safe_pkg.sv
// Shared constants for the rotary-dial safe: default geometry, datapath widths
// and the direction encoding used on the command interface.
package day2_safe_pkg;

  localparam int DEF_DIAL_SIZE = 100;
  localparam int DEF_START_POS = 50;
  localparam int POS_W         = 7;
  localparam int CNT_W         = 32;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/day2_div_const.sv
// Single-cycle unsigned 32-bit divide by a constant, built from a reciprocal
// multiply followed by a one-step remainder correction.
module day2_div_const
  import day2_safe_pkg::*;
#(
  parameter int DIVISOR = DEF_DIAL_SIZE
) (
  input  logic [CNT_W-1:0] dividend,
  output logic [CNT_W-1:0] quotient,
  output logic [POS_W-1:0] remainder
);

  // floor(2^32 / DIVISOR); the estimate it yields is either exact or one short.
  localparam logic [63:0] RECIP = 64'h1_0000_0000 / 64'(DIVISOR);
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIVISOR);

  logic [63:0]      prod;
  logic [CNT_W-1:0] q_est;
  logic [CNT_W-1:0] rem_est;
  logic [CNT_W-1:0] rem_fix;

  always_comb begin
    prod    = {32'd0, dividend} * RECIP;
    q_est   = CNT_W'(prod >> 32);
    rem_est = dividend - (q_est * DIV_C);
    if (rem_est >= DIV_C) begin
      quotient = q_est + 32'd1;
      rem_fix  = rem_est - DIV_C;
    end else begin
      quotient = q_est;
      rem_fix  = rem_est;
    end
    remainder = POS_W'(rem_fix);
  end

endmodule

// File: rtl/day2_safe.sv
// Rotary-dial safe: tracks the dial position and counts every click at which
// the dial points at 0, one command per cycle with no backpressure.
module day2_safe
  import day2_safe_pkg::*;
#(
  parameter int DIAL_SIZE = DEF_DIAL_SIZE,
  parameter int START_POS = DEF_START_POS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             dir,
  input  logic [31:0]      steps,
  output logic [31:0]      zero_count,
  output logic [6:0]       pos
);

  localparam logic [POS_W:0]   DIAL_W = (POS_W+1)'(DIAL_SIZE);
  localparam logic [POS_W-1:0] START  = POS_W'(START_POS);

  logic [CNT_W-1:0] q;
  logic [POS_W-1:0] r;

  logic [POS_W-1:0] pos_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             vld_p0;

  logic [POS_W-1:0] pos_nxt;
  logic [CNT_W-1:0] hits;

  day2_div_const #(
    .DIVISOR (DIAL_SIZE)
  ) u_div (
    .dividend  (steps),
    .quotient  (q),
    .remainder (r)
  );

  // Clockwise move: a carry past the top of the dial is a pass through 0.
  function automatic logic [POS_W:0] step_right(input logic [POS_W-1:0] p,
                                                input logic [POS_W-1:0] rr);
    logic [POS_W:0] sum;
    logic           wrap;
    sum  = {1'b0, p} + {1'b0, rr};
    wrap = (sum >= DIAL_W);
    step_right = {wrap, POS_W'(wrap ? (sum - DIAL_W) : sum)};
  endfunction

  // Counter-clockwise move: leaving 0 is not a hit, arriving at or crossing it is.
  function automatic logic [POS_W:0] step_left(input logic [POS_W-1:0] p,
                                               input logic [POS_W-1:0] rr);
    logic [POS_W:0] diff;
    logic           hit;
    diff = {1'b0, p} - {1'b0, rr};
    if (rr > p) diff = diff + DIAL_W;
    hit  = (p != '0) && (rr >= p);
    step_left = {hit, POS_W'(diff)};
  endfunction

  always_comb begin
    logic [POS_W:0] res;
    res = '0;
    if (dir == DIR_LEFT) res = step_left(pos_p0, r);
    else                 res = step_right(pos_p0, r);
    pos_nxt = res[POS_W-1:0];
    hits    = q + CNT_W'(res[POS_W]);
  end

  assign vld_p0 = valid;

  // Stage p0: architectural state, updated on the edge that samples the command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_p0 <= START;
      cnt_p0 <= '0;
    end else if (vld_p0) begin
      pos_p0 <= pos_nxt;
      cnt_p0 <= cnt_p0 + hits;
    end
  end

  assign pos        = pos_p0;
  assign zero_count = cnt_p0;

endmodule

// File: tb/tb_day2_safe.sv
// Directed self-checking bench for day2_safe with hand-computed expectations.
module tb_day2_safe;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        dir;
  logic [31:0] steps;
  logic [31:0] zero_count;
  logic [6:0]  pos;

  int tests;
  int fails;

  day2_safe dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .dir        (dir),
    .steps      (steps),
    .zero_count (zero_count),
    .pos        (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        seq_dir [10];
  logic [31:0] seq_stp [10];
  logic [6:0]  seq_pos [10];
  logic [31:0] seq_cnt [10];

  initial begin
    seq_dir = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    seq_stp = '{32'd68, 32'd30, 32'd48, 32'd5, 32'd60, 32'd55, 32'd1, 32'd99, 32'd14, 32'd82};
    seq_pos = '{7'd82, 7'd52, 7'd0, 7'd95, 7'd55, 7'd0, 7'd99, 7'd0, 7'd14, 7'd32};
    seq_cnt = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd4, 32'd4, 32'd5, 32'd5, 32'd6};
  end

  // One-cycle command pulse; returns at the next negedge with outputs updated.
  task automatic send(input logic d, input logic [31:0] s);
    @(negedge clk);
    valid = 1'b1;
    dir   = d;
    steps = s;
    @(negedge clk);
    valid = 1'b0;
    steps = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    valid = 1'b0;
    dir   = 1'b0;
    steps = 32'd0;
    @(negedge clk);
    valid = 1'b1;
    steps = 32'd33;
    @(negedge clk);
    dir   = 1'b1;
    steps = 32'd77;
    @(negedge clk);
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_hold: pos=%0d cnt=%0d want pos=50 cnt=0", pos, zero_count);
    end
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_release: pos=%0d cnt=%0d want pos=50 cnt=0", pos, zero_count);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(seq_dir[i], seq_stp[i]);
      tests++;
      if (pos !== seq_pos[i] || zero_count !== seq_cnt[i]) begin
        fails++;
        $display("FAIL seq_%0d: pos=%0d cnt=%0d want pos=%0d cnt=%0d",
                 i, pos, zero_count, seq_pos[i], seq_cnt[i]);
      end
      @(negedge clk);
      tests++;
      if (pos !== seq_pos[i] || zero_count !== seq_cnt[i]) begin
        fails++;
        $display("FAIL seq_idle_%0d: pos=%0d cnt=%0d want pos=%0d cnt=%0d",
                 i, pos, zero_count, seq_pos[i], seq_cnt[i]);
      end
    end
  endtask

  task automatic test_full_turns();
    do_reset();
    send(1'b0, 32'd1000);
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd10) begin
      fails++;
      $display("FAIL r1000: pos=%0d cnt=%0d want pos=50 cnt=10", pos, zero_count);
    end
    send(1'b1, 32'd1000);
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd20) begin
      fails++;
      $display("FAIL l1000: pos=%0d cnt=%0d want pos=50 cnt=20", pos, zero_count);
    end
  endtask

  task automatic test_zero_edges();
    do_reset();
    send(1'b1, 32'd50);
    tests++;
    if (pos !== 7'd0 || zero_count !== 32'd1) begin
      fails++;
      $display("FAIL l50: pos=%0d cnt=%0d want pos=0 cnt=1", pos, zero_count);
    end
    send(1'b1, 32'd0);
    tests++;
    if (pos !== 7'd0 || zero_count !== 32'd1) begin
      fails++;
      $display("FAIL l0_at_zero: pos=%0d cnt=%0d want pos=0 cnt=1", pos, zero_count);
    end
    send(1'b1, 32'd100);
    tests++;
    if (pos !== 7'd0 || zero_count !== 32'd2) begin
      fails++;
      $display("FAIL l100_from_zero: pos=%0d cnt=%0d want pos=0 cnt=2", pos, zero_count);
    end
    send(1'b0, 32'd99);
    tests++;
    if (pos !== 7'd99 || zero_count !== 32'd2) begin
      fails++;
      $display("FAIL r99_from_zero: pos=%0d cnt=%0d want pos=99 cnt=2", pos, zero_count);
    end
  endtask

  task automatic test_large_steps();
    // 0xFFFFFFFF = 42949672*100 + 95
    do_reset();
    send(1'b0, 32'hFFFF_FFFF);
    tests++;
    if (pos !== 7'd45 || zero_count !== 32'd42949673) begin
      fails++;
      $display("FAIL rmax: pos=%0d cnt=%0d want pos=45 cnt=42949673", pos, zero_count);
    end
    send(1'b1, 32'hFFFF_FFFF);
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd85899346) begin
      fails++;
      $display("FAIL lmax: pos=%0d cnt=%0d want pos=50 cnt=85899346", pos, zero_count);
    end
    send(1'b0, 32'd199);
    tests++;
    if (pos !== 7'd49 || zero_count !== 32'd85899348) begin
      fails++;
      $display("FAIL r199: pos=%0d cnt=%0d want pos=49 cnt=85899348", pos, zero_count);
    end
    send(1'b1, 32'd49);
    tests++;
    if (pos !== 7'd0 || zero_count !== 32'd85899349) begin
      fails++;
      $display("FAIL l49_exact: pos=%0d cnt=%0d want pos=0 cnt=85899349", pos, zero_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    valid = 1'b1;
    dir   = 1'b0;
    steps = 32'd50;
    @(negedge clk);
    tests++;
    if (pos !== 7'd0 || zero_count !== 32'd1) begin
      fails++;
      $display("FAIL b2b_first: pos=%0d cnt=%0d want pos=0 cnt=1", pos, zero_count);
    end
    steps = 32'd100;
    @(negedge clk);
    valid = 1'b0;
    tests++;
    if (pos !== 7'd0 || zero_count !== 32'd2) begin
      fails++;
      $display("FAIL b2b_second: pos=%0d cnt=%0d want pos=0 cnt=2", pos, zero_count);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    send(1'b0, 32'd10);
    tests++;
    if (pos !== 7'd60 || zero_count !== 32'd0) begin
      fails++;
      $display("FAIL pre_reset: pos=%0d cnt=%0d want pos=60 cnt=0", pos, zero_count);
    end
    @(negedge clk);
    valid = 1'b1;
    dir   = 1'b0;
    steps = 32'd75;
    rst   = 1'b0;
    #1;
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: pos=%0d cnt=%0d want pos=50 cnt=0", pos, zero_count);
    end
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    tests++;
    if (pos !== 7'd50 || zero_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_drop_cmd: pos=%0d cnt=%0d want pos=50 cnt=0", pos, zero_count);
    end
    send(1'b0, 32'd75);
    tests++;
    if (pos !== 7'd25 || zero_count !== 32'd1) begin
      fails++;
      $display("FAIL post_reset_r75: pos=%0d cnt=%0d want pos=25 cnt=1", pos, zero_count);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sequence();
    test_full_turns();
    test_zero_edges();
    test_large_steps();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/day2_safe.md
Name: day2_safe

Overview:
- Rotary-dial "safe" model. Dial positions run 0..DIAL_SIZE-1 and start at START_POS.
- Each valid command rotates the dial left or right by a 32-bit click count.
- The block counts every click at which the dial points at 0: clicks passed through mid-rotation and the final landing position both count.
- Standalone streaming datapath fed by a command source (file reader / host). The outputs are the running password count and the current dial position.

Parameters:
- DIAL_SIZE, 100, number of dial positions; pos width is fixed at 7 bits, so DIAL_SIZE ≤ 128.
- START_POS, 50, dial position after reset; must be < DIAL_SIZE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- valid  input  1  command strobe; one command accepted per cycle in which valid=1.
- dir  input  1  rotation direction: 1 = left (decreasing), 0 = right (increasing).
- steps  input  32  unsigned click count of the command.
- zero_count  output  32  running count of clicks landing on 0.
- pos  output  7  current dial position, 0..DIAL_SIZE-1.

Behaviour:
- Reset (rst=0, async): pos=START_POS, zero_count=0. Both are held while rst=0 and valid is ignored.
- No backpressure: the block accepts a command on every rising edge with valid=1, back-to-back included. When valid=0, state holds.
- Latency: a command sampled on edge N updates pos and zero_count at that edge; the new values are visible after edge N.
- Quotient/remainder: q = steps / DIAL_SIZE, r = steps % DIAL_SIZE. Both are computed combinationally in the same cycle (constant-divisor divider); no multicycle iteration.
- Right (dir=0), from position p:
  - hits = q + (p + r ≥ DIAL_SIZE ? 1 : 0)
  - pos' = (p + r) mod DIAL_SIZE
- Left (dir=1), from position p:
  - hits = q + ((p ≠ 0 && r ≥ p) ? 1 : 0)
  - pos' = (p − r) mod DIAL_SIZE, i.e. p − r, or p − r + DIAL_SIZE when r > p.
  - Starting on 0 does not count as a hit; only arriving at 0 does.
- zero_count' = zero_count + hits, modulo 2^32 (silent wrap, no saturation).
- steps=0: hits=0, pos unchanged, even when p=0.
- Full-turn multiples (e.g. steps=1000): q full revolutions each count once; pos returns to p.
- Reset mid-stream: an asserted reset overrides any concurrent valid; that command is dropped.
- All arithmetic is unsigned. Intermediate p+r needs 8 bits; hits fits 32 bits.

Decomposition:
- Shared package: DIAL_SIZE/START_POS defaults, POS_W=7, CNT_W=32, and the direction encoding constants DIR_RIGHT=0, DIR_LEFT=1.
- One sub-module, day2_div_const: combinational 32-bit unsigned divide by the constant DIAL_SIZE (reciprocal multiply plus correction), outputting quotient (32 b) and remainder (7 b).
- The top module holds the pos/zero_count registers and the hit/position update logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → pos=50, zero_count=0; toggling valid/steps during reset leaves both unchanged.
- Sequence L68,L30,R48,L5,R60,L55,L1,L99,R14,L82, each a one-cycle valid pulse followed by one idle cycle → final pos=32, zero_count=6. Intermediate pos values: 82,52,0,95,55,0,99,0,14,32.
- From reset, R1000 → zero_count=10, pos=50. Then L1000 → zero_count=20, pos=50.
- From reset, L50 → count 1, pos 0. Then L0 → unchanged. Then L100 → count 2, pos 0. Then R99 → count 2, pos 99.
- Back-to-back valid (no idle): R50 then R100 on consecutive cycles → pos 0 then 0; zero_count 1 then 2.
- Assert rst mid-stream in the same cycle as valid=1, R75 → after release, pos=50, zero_count=0, and the command has no effect.
